// File: rtl/alu_pkg.sv
// Shared ALU definitions: SELECT op codes, divider sequencer states and
// op-code decode helpers used by the ALU and the divide sequencer.
package alu_pkg;

  // 5-bit SELECT op codes for the divide class.
  localparam logic [4:0] SEL_DIV  = 5'b10001;
  localparam logic [4:0] SEL_DIVU = 5'b10101;
  localparam logic [4:0] SEL_REM  = 5'b11001;
  localparam logic [4:0] SEL_REMU = 5'b11101;

  // Divide sequencer states; IDLE encodes as zero so reset lands here.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

  // True for any of the four divide-class op codes.
  function automatic logic is_div_op(input logic [4:0] sel);
    return (sel == SEL_DIV) || (sel == SEL_DIVU) ||
           (sel == SEL_REM) || (sel == SEL_REMU);
  endfunction

  // True for the signed variants (DIV, REM).
  function automatic logic is_signed_op(input logic [4:0] sel);
    return (sel == SEL_DIV) || (sel == SEL_REM);
  endfunction

  // True when the op returns the remainder rather than the quotient.
  function automatic logic is_rem_op(input logic [4:0] sel);
    return (sel == SEL_REM) || (sel == SEL_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on {rem, quo}: shift left by one,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            ge;

  // Shift, subtract at XLEN+1 bits and use the borrow bit as the compare.
  // When the shifted remainder overflows XLEN bits it exceeds any divisor,
  // and the low XLEN bits of the difference are still exact.
  always_comb begin
    rem_sh = {rem_i, quo_i[XLEN-1]};
    diff   = {1'b0, rem_sh[XLEN-1:0]} - {1'b0, divisor_i};
    ge     = rem_sh[XLEN] | ~diff[XLEN];
    rem_o  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_o  = {quo_i[XLEN-2:0], ge};
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer (DIV, DIVU, REM, REMU).
// Handshake: an op is accepted on a rising CLK edge where START=1, SELECT is a
// divide op and the sequencer is IDLE or DONE; BUSY is high from the cycle
// after acceptance until the result is ready, then DONE pulses for one cycle
// with RESULT valid. RESULT holds until overwritten by a later operation.
module div_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT,
  output logic [2:0]      DBG_STATE
);

  localparam int              CNT_W     = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [XLEN-1:0]  quo_q, quo_d;       // dividend, then quotient as it forms
  logic [XLEN-1:0]  dvs_q, dvs_d;       // divisor
  logic [XLEN-1:0]  rem_q, rem_d;       // partial remainder
  logic [XLEN-1:0]  result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_signed_q, is_signed_d;
  logic             is_rem_q, is_rem_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;

  logic             accept;
  logic             dvd_neg, dvs_neg, dvs_zero, is_ovf;
  logic [XLEN-1:0]  dvd_abs, dvs_abs, quo_fix, rem_fix;
  logic [XLEN-1:0]  step_rem, step_quo;

  // In PREP, quo_q/dvs_q still hold the raw operands captured at accept.
  assign accept   = START && is_div_op(SELECT) &&
                    ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign dvd_neg  = is_signed_q & quo_q[XLEN-1];
  assign dvs_neg  = is_signed_q & dvs_q[XLEN-1];
  assign dvd_abs  = dvd_neg ? -quo_q : quo_q;
  assign dvs_abs  = dvs_neg ? -dvs_q : dvs_q;
  assign dvs_zero = (dvs_q == '0);
  assign is_ovf   = is_signed_q && (quo_q == INT_MIN) && (dvs_q == '1);
  assign quo_fix  = qsign_q ? -quo_q : quo_q;
  assign rem_fix  = rsign_q ? -rem_q : rem_q;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Next-state and datapath update; every target defaults to hold.
  always_comb begin
    state_d     = state_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    is_signed_d = is_signed_q;
    is_rem_d    = is_rem_q;
    qsign_d     = qsign_q;
    rsign_d     = rsign_q;

    if (FLUSH) begin
      // Abort wins over everything, including a simultaneous START.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state_d     = ST_PREP;
            quo_d       = DATA1;
            dvs_d       = DATA2;
            is_signed_d = is_signed_op(SELECT);
            is_rem_d    = is_rem_op(SELECT);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PREP: begin
          quo_d   = dvd_abs;
          dvs_d   = dvs_abs;
          rem_d   = '0;
          cnt_d   = '0;
          // A zero divisor must give an all-ones quotient whatever the
          // dividend sign, so the iterative path never negates it.
          qsign_d = (dvd_neg ^ dvs_neg) & ~dvs_zero;
          rsign_d = dvd_neg;
          if ((EARLY_OUT != 0) && dvs_zero) begin
            state_d  = ST_DONE;
            result_d = is_rem_q ? quo_q : '1;
          end else if ((EARLY_OUT != 0) && is_ovf) begin
            state_d  = ST_DONE;
            result_d = is_rem_q ? '0 : INT_MIN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == LAST_ITER) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_FIX: begin
          result_d = is_rem_q ? rem_fix : quo_fix;
          state_d  = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      quo_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      is_signed_q <= 1'b0;
      is_rem_q    <= 1'b0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      is_signed_q <= is_signed_d;
      is_rem_q    <= is_rem_d;
      qsign_q     <= qsign_d;
      rsign_q     <= rsign_d;
    end
  end

  // Outputs decode directly from the registered state.
  always_comb begin
    BUSY      = (state_q == ST_PREP) || (state_q == ST_RUN) || (state_q == ST_FIX);
    DONE      = (state_q == ST_DONE);
    RESULT    = result_q;
    DBG_STATE = state_q;
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Testbench for div_sequencer: two instances (early-out on and off) share one
// stimulus stream; a scoreboard per instance checks RESULT and DONE timing.
module tb_div_sequencer;
  import alu_pkg::*;

  localparam int XLEN = 32;

  // ---------------- clock / reset / DUTs ----------------
  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [4:0]  SELECT;
  logic [31:0] DATA1, DATA2;
  logic        FLUSH;
  logic        busy0, done0, busy1, done1;
  logic [31:0] res0, res1;
  logic [2:0]  st0, st1;

  always #5 CLK = ~CLK;

  div_sequencer #(.XLEN(XLEN), .EARLY_OUT(1)) dut_eo (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
    .BUSY(busy0), .DONE(done0), .RESULT(res0), .DBG_STATE(st0)
  );

  div_sequencer #(.XLEN(XLEN), .EARLY_OUT(0)) dut_it (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
    .BUSY(busy1), .DONE(done1), .RESULT(res1), .DBG_STATE(st1)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      SEL_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      SEL_REMU: return (b == 0) ? a : a % b;
      SEL_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
    endcase
  endfunction

  // Cycles from accept edge to the cycle where DONE is seen.
  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input bit early);
    bit sgn;
    sgn = (op == SEL_DIV) || (op == SEL_REM);
    if (early && (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  // ---------------- scoreboard / monitors ----------------
  logic [31:0] exp_q0[$], exp_q1[$];
  int          due_q0[$], due_q1[$];

  always @(negedge CLK) begin
    if (done0) begin
      if (exp_q0.size() == 0) chk("eo_spurious_done", {31'b0, done0}, 32'd0);
      else begin
        chk("eo_result", res0, exp_q0.pop_front());
        chk("eo_latency", cyc, due_q0.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    if (done1) begin
      if (exp_q1.size() == 0) chk("it_spurious_done", {31'b0, done1}, 32'd0);
      else begin
        chk("it_result", res1, exp_q1.pop_front());
        chk("it_latency", cyc, due_q1.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) chk("wait_idle_timeout", {31'b0, busy0 | busy1}, 32'd0);
  endtask

  // Called at a negedge; drives one op for one cycle, optionally scoring it.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit score);
    int acc;
    wait_idle();
    START  = 1'b1;
    SELECT = op;
    DATA1  = a;
    DATA2  = b;
    acc    = cyc + 1;
    if (score) begin
      exp_q0.push_back(ref_result(op, a, b));
      due_q0.push_back(acc + ref_latency(op, a, b, 1'b1));
      exp_q1.push_back(ref_result(op, a, b));
      due_q1.push_back(acc + ref_latency(op, a, b, 1'b0));
    end
    @(negedge CLK);
    START  = 1'b0;
    SELECT = 5'b00000;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom();
    endcase
  endfunction

  logic [4:0]  dir_op[10];
  logic [31:0] dir_a[10], dir_b[10];
  logic [4:0]  op_tab[4];

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] keep0, keep1;
    RESET_N = 1'b0;
    START   = 1'b0;
    SELECT  = 5'b0;
    DATA1   = '0;
    DATA2   = '0;
    FLUSH   = 1'b0;
    op_tab  = '{SEL_DIV, SEL_DIVU, SEL_REM, SEL_REMU};
    dir_op  = '{SEL_DIV, SEL_REM, SEL_DIVU, SEL_REMU, SEL_DIV,
                SEL_REM, SEL_DIV, SEL_REM, SEL_DIVU, SEL_REMU};
    dir_a   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd100, 32'd5,
                32'd5, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'hFFFF_FFFB};
    dir_b   = '{32'd2, 32'd2, 32'h10, 32'd7, 32'd0,
                32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};

    #12;
    chk("reset_busy", {31'b0, busy0}, 32'd0);
    chk("reset_done", {31'b0, done0}, 32'd0);
    chk("reset_result", res0, 32'd0);
    chk("reset_state", {29'b0, st0}, 32'(ST_IDLE));
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Directed table; consecutive issues land in the previous DONE cycle.
    for (int i = 0; i < 10; i++) begin
      issue(dir_op[i], dir_a[i], dir_b[i], 1'b1);
      chk("busy_after_accept", {31'b0, busy0 & busy1}, 32'd1);
    end
    wait_idle();

    // Non-divide START held: nothing happens.
    START = 1'b1;
    for (int i = 0; i < 6; i++) begin
      SELECT = (i == 0) ? 5'b00000 : 5'($urandom_range(0, 15));
      @(negedge CLK);
      chk("nondiv_busy", {31'b0, busy0 | busy1}, 32'd0);
      chk("nondiv_state", {29'b0, st0}, 32'(ST_IDLE));
    end
    // FLUSH beats a simultaneous valid START.
    SELECT = SEL_DIV;
    FLUSH  = 1'b1;
    @(negedge CLK);
    chk("flush_vs_start", {31'b0, busy0 | busy1}, 32'd0);
    START  = 1'b0;
    FLUSH  = 1'b0;
    SELECT = 5'b0;

    // FLUSH mid-RUN: BUSY drops, no DONE, RESULT unchanged.
    keep0 = res0;
    keep1 = res1;
    issue(SEL_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    repeat (11) @(negedge CLK);
    chk("run_state_before_flush", {29'b0, st0}, 32'(ST_RUN));
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    chk("flush_busy", {31'b0, busy0 | busy1}, 32'd0);
    chk("flush_result_eo", res0, keep0);
    chk("flush_result_it", res1, keep1);
    repeat (40) @(negedge CLK);

    // Asynchronous reset mid-RUN.
    issue(SEL_DIVU, 32'd1000, 32'd7, 1'b1);
    repeat (10) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("areset_busy", {31'b0, busy0 | busy1}, 32'd0);
    chk("areset_done", {31'b0, done0 | done1}, 32'd0);
    chk("areset_result_eo", res0, 32'd0);
    chk("areset_result_it", res1, 32'd0);
    exp_q0.delete();
    due_q0.delete();
    exp_q1.delete();
    due_q1.delete();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    issue(SEL_DIVU, 32'd10, 32'd3, 1'b1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      issue(op_tab[$urandom_range(0, 3)], rnd_opnd(), rnd_opnd(), 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end

    wait_idle();
    repeat (3) @(negedge CLK);
    chk("eo_queue_drained", 32'(exp_q0.size()), 32'd0);
    chk("it_queue_drained", 32'(exp_q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
